scanline_shader: RTL and testbench
==================================

Name: scanline_shader

Overview:
- Post-processing stage directly downstream of the scandoubler.
- Consumes the doubled-rate video stream (ce_pix_out, syncs, blanks, RGB) and darkens every second output line by a selectable amount, producing the classic CRT scanline look.
- Syncs and blanks are delayed through the same pipeline as colour, so the downstream video mixer and HDMI path see aligned timing.

Parameters:
- HALF_DEPTH, 0, 1 selects 4-bit colour components; 0 selects 8-bit. Internal DWIDTH = HALF_DEPTH ? 3 : 7.

Ports:
- clk_vid  input  1  video clock; all logic on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- scanlines  input  2  darkening mode: 0 off, 1 = 75% brightness, 2 = 50%, 3 = 25%
- ce_pix  input  1  pixel enable from scandoubler (doubled rate)
- hs_in  input  1  horizontal sync, active high
- vs_in  input  1  vertical sync, active high
- hb_in  input  1  horizontal blank
- vb_in  input  1  vertical blank
- r_in, g_in, b_in  input  DWIDTH+1 each  colour components
- ce_pix_out  output  1  registered copy of ce_pix (1 clk delay)
- hs_out, vs_out, hb_out, vb_out  output  1 each  delayed syncs/blanks
- r_out, g_out, b_out  output  DWIDTH+1 each  shaded colour
- line_odd  output  1  current line parity, for debug/visibility

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0; line parity 0; active_mode 0; pipeline registers 0. Deassertion takes effect on the next clk_vid edge.
- Edge detection runs every clk_vid, not gated by ce_pix. Previous hs_in/vs_in registers reset to 0.
- Mode latch: on the rising edge of vs_in, active_mode <= scanlines. The mode never changes mid-frame.
- Line parity:
  - Toggles on each rising edge of hs_in.
  - Forced to 0 on the rising edge of vs_in.
  - If both rise in the same cycle, vs wins and parity = 0.
  - line_odd = parity.
- Pipeline, advancing only on cycles with ce_pix = 1:
  - Stage 1 captures RGB, hs/vs/hb/vb and dark = (active_mode != 0) & parity.
  - Stage 2 drives the outputs.
  - Latency: 2 ce_pix beats for every output. Outputs hold between beats.
- Shading arithmetic, per component x (unsigned, DWIDTH+1 bits, no widening, never overflows):
  - mode 1: x - (x >> 2)
  - mode 2: x >> 1
  - mode 3: x >> 2
  - dark = 0: x unchanged
- Blanking: if the stage-1 hb or vb is set, output RGB = 0 regardless of dark.
- ce_pix_out <= ce_pix every clk (1 clk delay), so downstream sampling aligns with output updates.
- ce_pix held low: the pipeline freezes, but parity and mode-latch edge detection keep running.
- Reset mid-line: parity restarts at 0. The first line after reset is undarkened until the next hs edge.

Optional Feature:
- Macro SCANLINE_INVERT_EN.
- When defined:
  - Adds input port scan_invert (1 bit), latched alongside scanlines at the vs_in rising edge into active_invert (reset 0).
  - dark = (active_mode != 0) & (parity ^ active_invert), i.e. even lines darken instead.
  - line_odd still reports raw parity.
- When undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- Reset: hold reset_n low with random inputs -> all outputs 0 and line_odd 0. Release; with scanlines=2 but no vs edge yet -> no darkening, since active_mode is still 0.
- Latency: scanlines=0, vs pulse, ce_pix every 2nd clk, r_in=0x80 on one beat -> r_out=0x80 exactly 2 ce_pix beats later. hs_out follows hs_in with the same 2-beat delay.
- Modes: vs pulse with scanlines=1/2/3; on an odd line (after 1 hs edge) with r=g=b=0xFF -> out 0xC0/0x7F/0x3F. On the even line -> 0xFF.
- Blanking and width: hb_in=1 on an odd line with RGB=0xFF -> out 0. With HALF_DEPTH=1 and mode 1, x=0xF -> 0xC.
- Edge cases: scanlines changed mid-frame -> no effect until the next vs. hs and vs rising in the same cycle -> parity 0. Three hs edges -> line_odd = 1.
- SCANLINE_INVERT_EN defined: scan_invert=1 latched at vs, mode 2, RGB=0x40 -> even lines output 0x20, odd lines output 0x40.

Source files
------------

// File: rtl/scanline_shader.sv
// scanline_shader: darkens every second scandoubled line, with syncs/blanks delayed alongside colour.
// Optional macro SCANLINE_INVERT_EN adds scan_invert, which moves the darkening to even lines.
module scanline_shader #(
  parameter int HALF_DEPTH = 0,
  localparam int DWIDTH = (HALF_DEPTH != 0) ? 3 : 7
) (
  input  logic              clk_vid,
  input  logic              reset_n,
  input  logic [1:0]        scanlines,
`ifdef SCANLINE_INVERT_EN
  input  logic              scan_invert,
`endif
  input  logic              ce_pix,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              hb_in,
  input  logic              vb_in,
  input  logic [DWIDTH:0]   r_in,
  input  logic [DWIDTH:0]   g_in,
  input  logic [DWIDTH:0]   b_in,
  output logic              ce_pix_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              hb_out,
  output logic              vb_out,
  output logic [DWIDTH:0]   r_out,
  output logic [DWIDTH:0]   g_out,
  output logic [DWIDTH:0]   b_out,
  output logic              line_odd
);

  logic            hs_prev;
  logic            vs_prev;
  logic            hs_rise;
  logic            vs_rise;
  logic            parity;
  logic [1:0]      active_mode;
  logic            dark_now;

  logic            s1_hs;
  logic            s1_vs;
  logic            s1_hb;
  logic            s1_vb;
  logic            s1_blank;
  logic            s1_dark;
  logic [1:0]      s1_mode;
  logic [DWIDTH:0] s1_r;
  logic [DWIDTH:0] s1_g;
  logic [DWIDTH:0] s1_b;

  // Every mode only ever subtracts from x, so the result fits without widening.
  function automatic logic [DWIDTH:0] shade(input logic [DWIDTH:0] x, input logic [1:0] mode);
    case (mode)
      2'd1:    shade = x - (x >> 2);
      2'd2:    shade = x >> 1;
      2'd3:    shade = x >> 2;
      default: shade = x;
    endcase
  endfunction

  assign hs_rise  = hs_in & ~hs_prev;
  assign vs_rise  = vs_in & ~vs_prev;
  assign line_odd = parity;

`ifdef SCANLINE_INVERT_EN
  logic active_invert;

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      active_invert <= 1'b0;
    end else if (vs_rise) begin
      active_invert <= scan_invert;
    end
  end

  assign dark_now = (active_mode != 2'd0) & (parity ^ active_invert);
`else
  assign dark_now = (active_mode != 2'd0) & parity;
`endif

  // Edge detection and mode latch run every clock; vs wins over a simultaneous hs edge.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      parity      <= 1'b0;
      active_mode <= 2'd0;
    end else begin
      hs_prev <= hs_in;
      vs_prev <= vs_in;
      if (vs_rise) begin
        active_mode <= scanlines;
        parity      <= 1'b0;
      end else if (hs_rise) begin
        parity <= ~parity;
      end
    end
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      ce_pix_out <= 1'b0;
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
      s1_hb      <= 1'b0;
      s1_vb      <= 1'b0;
      s1_blank   <= 1'b0;
      s1_dark    <= 1'b0;
      s1_mode    <= 2'd0;
      s1_r       <= '0;
      s1_g       <= '0;
      s1_b       <= '0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      hb_out     <= 1'b0;
      vb_out     <= 1'b0;
      r_out      <= '0;
      g_out      <= '0;
      b_out      <= '0;
    end else begin
      ce_pix_out <= ce_pix;
      if (ce_pix) begin
        s1_hs    <= hs_in;
        s1_vs    <= vs_in;
        s1_hb    <= hb_in;
        s1_vb    <= vb_in;
        s1_blank <= hb_in | vb_in;
        s1_dark  <= dark_now;
        s1_mode  <= active_mode;
        s1_r     <= r_in;
        s1_g     <= g_in;
        s1_b     <= b_in;

        hs_out <= s1_hs;
        vs_out <= s1_vs;
        hb_out <= s1_hb;
        vb_out <= s1_vb;
        r_out  <= s1_blank ? '0 : (s1_dark ? shade(s1_r, s1_mode) : s1_r);
        g_out  <= s1_blank ? '0 : (s1_dark ? shade(s1_g, s1_mode) : s1_g);
        b_out  <= s1_blank ? '0 : (s1_dark ? shade(s1_b, s1_mode) : s1_b);
      end
    end
  end

endmodule

// File: tb/tb_scanline_shader.sv
// Bench for scanline_shader: a queue-based reference model checked every cycle, plus directed literal checks.
module tb_scanline_shader;

  logic       clk_vid = 1'b0;
  always #5 clk_vid = ~clk_vid;

  logic       reset_n;
  logic [1:0] scanlines;
  logic       ce_pix, hs_in, vs_in, hb_in, vb_in;
  logic [7:0] r_in, g_in, b_in;
`ifdef SCANLINE_INVERT_EN
  logic       scan_invert;
`endif

  logic       ce_pix_out, hs_out, vs_out, hb_out, vb_out, line_odd;
  logic [7:0] r_out, g_out, b_out;
  logic       ce_h, hs_h, vs_h, hb_h, vb_h, odd_h;
  logic [3:0] r_h, g_h, b_h;

  scanline_shader #(.HALF_DEPTH(0)) dut (
    .clk_vid(clk_vid), .reset_n(reset_n), .scanlines(scanlines),
`ifdef SCANLINE_INVERT_EN
    .scan_invert(scan_invert),
`endif
    .ce_pix(ce_pix), .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .ce_pix_out(ce_pix_out), .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .line_odd(line_odd)
  );

  scanline_shader #(.HALF_DEPTH(1)) dut_half (
    .clk_vid(clk_vid), .reset_n(reset_n), .scanlines(scanlines),
`ifdef SCANLINE_INVERT_EN
    .scan_invert(scan_invert),
`endif
    .ce_pix(ce_pix), .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
    .r_in(r_in[3:0]), .g_in(g_in[3:0]), .b_in(b_in[3:0]),
    .ce_pix_out(ce_h), .hs_out(hs_h), .vs_out(vs_h), .hb_out(hb_h), .vb_out(vb_h),
    .r_out(r_h), .g_out(g_h), .b_out(b_h), .line_odd(odd_h)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each ce beat pushes the finished pixel; outputs show the beat before the newest.
  typedef struct packed {
    logic       hs, vs, hb, vb;
    logic [7:0] r, g, b;
    logic [3:0] rh, gh, bh;
  } rec_t;

  rec_t q[$];
  rec_t nrec;
  rec_t e;
  logic m_par, m_inv, m_ce, phs, pvs, m_dark, m_blank;
  int   m_mode;

  function automatic int shade(input int x, input int mode);
    case (mode)
      1:       return x - x / 4;
      2:       return x / 2;
      3:       return x / 4;
      default: return x;
    endcase
  endfunction

  function automatic int pix(input int x, input int mode, input logic dark, input logic blank);
    if (blank) return 0;
    return dark ? shade(x, mode) : x;
  endfunction

  always @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_par = 0; m_mode = 0; m_inv = 0; m_ce = 0; phs = 0; pvs = 0;
    end else begin
      if (ce_pix) begin
        m_dark  = (m_mode != 0) && (m_par ^ m_inv);
        m_blank = hb_in || vb_in;
        nrec.hs = hs_in; nrec.vs = vs_in; nrec.hb = hb_in; nrec.vb = vb_in;
        nrec.r  = 8'(pix(int'(r_in), m_mode, m_dark, m_blank));
        nrec.g  = 8'(pix(int'(g_in), m_mode, m_dark, m_blank));
        nrec.b  = 8'(pix(int'(b_in), m_mode, m_dark, m_blank));
        nrec.rh = 4'(pix(int'(r_in[3:0]), m_mode, m_dark, m_blank));
        nrec.gh = 4'(pix(int'(g_in[3:0]), m_mode, m_dark, m_blank));
        nrec.bh = 4'(pix(int'(b_in[3:0]), m_mode, m_dark, m_blank));
        q.push_back(nrec);
        if (q.size() > 2) void'(q.pop_front());
      end
      m_ce = ce_pix;
      if (vs_in && !pvs) begin
        m_mode = int'(scanlines);
        m_par  = 1'b0;
`ifdef SCANLINE_INVERT_EN
        m_inv  = scan_invert;
`endif
      end else if (hs_in && !phs) begin
        m_par = !m_par;
      end
      phs = hs_in;
      pvs = vs_in;
    end
  end

  always @(negedge clk_vid) begin
    e = (q.size() == 2) ? q[0] : '0;
    chk("ctrl", {ce_pix_out, hs_out, vs_out, hb_out, vb_out, line_odd},
                {m_ce, e.hs, e.vs, e.hb, e.vb, m_par});
    chk("rgb", {r_out, g_out, b_out}, {e.r, e.g, e.b});
    chk("half", {ce_h, hs_h, vs_h, hb_h, vb_h, odd_h, r_h, g_h, b_h},
                {m_ce, e.hs, e.vs, e.hb, e.vb, m_par, e.rh, e.gh, e.bh});
  end

  task automatic tick();
    @(posedge clk_vid);
    #2;
  endtask

  task automatic hs_pulse();
    hs_in = 1'b1; tick();
    hs_in = 1'b0; tick();
  endtask

  task automatic vs_pulse(input logic [1:0] mode);
    scanlines = mode;
    vs_in = 1'b1; tick();
    vs_in = 1'b0; tick();
  endtask

  task automatic beats2(input logic [7:0] v);
    ce_pix = 1'b1; r_in = v; g_in = v; b_in = v;
    tick(); tick();
    ce_pix = 1'b0;
  endtask

  logic [7:0] exp_odd [4];
  logic [3:0] exp_half [4];

  initial begin
    exp_odd  = '{8'hFF, 8'hC0, 8'h7F, 8'h3F};
    exp_half = '{4'hF, 4'hC, 4'h7, 4'h3};
    reset_n = 1'b0; scanlines = 2'd0;
    ce_pix = 0; hs_in = 0; vs_in = 0; hb_in = 0; vb_in = 0;
    r_in = 0; g_in = 0; b_in = 0;
`ifdef SCANLINE_INVERT_EN
    scan_invert = 1'b0;
`endif
    for (int i = 0; i < 6; i++) begin
      ce_pix = 1'($urandom); hs_in = 1'($urandom); vs_in = 1'($urandom);
      r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
      scanlines = 2'($urandom);
      tick();
    end
    chk("reset_rgb", {r_out, g_out, b_out, ce_pix_out, hs_out}, 26'd0);
    chk("reset_odd", line_odd, 1'b0);

    ce_pix = 0; hs_in = 0; vs_in = 0; hb_in = 0; vb_in = 0; scanlines = 2'd2;
    reset_n = 1'b1; tick();
    hs_pulse();
    chk("no_vs_odd", line_odd, 1'b1);
    beats2(8'hFF);
    chk("no_vs_undark", r_out, 8'hFF);

    for (int m = 1; m <= 3; m++) begin
      vs_pulse(2'(m));
      hs_pulse();
      beats2(8'hFF);
      chk("mode_odd", {r_out, g_out, b_out}, {3{exp_odd[m]}});
      chk("mode_odd_half", r_h, exp_half[m]);
      hs_pulse();
      beats2(8'hFF);
      chk("mode_even", r_out, 8'hFF);
    end

    vs_pulse(2'd2); hs_pulse();
    hb_in = 1'b1; beats2(8'hFF); hb_in = 1'b0;
    chk("blank", {r_out, g_out, b_out, hb_out}, {24'd0, 1'b1});

    vs_pulse(2'd0);
    ce_pix = 1; r_in = 8'h80; hs_in = 1; tick();
    ce_pix = 0; r_in = 8'h00; tick();
    chk("lat_beat1", {r_out, hs_out}, {8'h00, 1'b0});
    ce_pix = 1; hs_in = 0; tick();
    chk("lat_beat2", {r_out, hs_out}, {8'h80, 1'b1});
    ce_pix = 0; tick();
    chk("lat_hold", {r_out, hs_out, ce_pix_out}, {8'h80, 1'b1, 1'b0});
    ce_pix = 1; tick();
    chk("lat_beat3", {r_out, hs_out, ce_pix_out}, {8'h00, 1'b0, 1'b1});
    ce_pix = 0;

    vs_pulse(2'd1); hs_pulse();
    scanlines = 2'd3;
    beats2(8'hFF);
    chk("mid_frame", r_out, 8'hC0);

    hs_pulse();
    hs_pulse();
    chk("pre_same", line_odd, 1'b1);
    hs_in = 1; vs_in = 1; tick();
    chk("hs_vs_same", line_odd, 1'b0);
    hs_in = 0; vs_in = 0; tick();

    vs_pulse(2'd0);
    hs_pulse(); hs_pulse(); hs_pulse();
    chk("three_hs", line_odd, 1'b1);

`ifdef SCANLINE_INVERT_EN
    scan_invert = 1'b1;
    vs_pulse(2'd2);
    scan_invert = 1'b0;
    beats2(8'h40);
    chk("inv_even", r_out, 8'h20);
    hs_pulse();
    beats2(8'h40);
    chk("inv_odd", r_out, 8'h40);
`endif

    for (int i = 0; i < 5000; i++) begin
      ce_pix = 1'($urandom);
      hs_in = ($urandom_range(0, 15) == 0);
      vs_in = ($urandom_range(0, 299) == 0);
      hb_in = ($urandom_range(0, 7) == 0);
      vb_in = ($urandom_range(0, 15) == 0);
      r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
      scanlines = 2'($urandom);
`ifdef SCANLINE_INVERT_EN
      scan_invert = 1'($urandom);
`endif
      reset_n = ($urandom_range(0, 999) != 0);
      tick();
    end
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
